// File: rtl/f2v_pkg.sv
// Shared widths, FSM encoding and the elaboration-time scale constant for square_wave_f2v.
package f2v_pkg;

    localparam int unsigned PERIOD_W = 32;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ITER_W   = 5;

    localparam logic [PERIOD_W-1:0] OUT_MAX = 32'd32767;

    typedef enum logic {
        WAIT_FIRST,
        MEASURE
    } f2v_state_e;

    // K = 32767 * clock_rate / f_full_scale, so K / period lands full scale at f_full_scale.
    function automatic logic [63:0] calc_k(input logic [63:0] clock_rate,
                                           input logic [63:0] f_full_scale);
        return (64'd32767 * clock_rate) / f_full_scale;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Takes 32 busy cycles after start and then pulses done for one cycle with the quotient held.
module seq_divider
    import f2v_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [PERIOD_W-1:0] dividend,
    input  logic [PERIOD_W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [PERIOD_W-1:0] quotient
);

    logic [PERIOD_W-1:0] rem_q;
    logic [PERIOD_W-1:0] quo_q;
    logic [PERIOD_W-1:0] div_q;
    logic [ITER_W-1:0]   iter_q;
    logic [PERIOD_W:0]   shifted_c;
    logic [PERIOD_W:0]   diff_c;
    logic                fits_c;

    assign shifted_c = {rem_q, quo_q[PERIOD_W-1]};
    assign diff_c    = shifted_c - {1'b0, div_q};
    assign fits_c    = shifted_c >= {1'b0, div_q};
    assign quotient  = quo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            iter_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem_q  <= fits_c ? PERIOD_W'(diff_c) : PERIOD_W'(shifted_c);
                quo_q  <= {quo_q[PERIOD_W-2:0], fits_c};
                iter_q <= iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(PERIOD_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                rem_q  <= '0;
                quo_q  <= dividend;
                div_q  <= divisor;
                iter_q <= '0;
                busy   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/square_wave_f2v.sv
// Square-wave frequency-to-voltage converter: hysteresis edge detect, period count, K/P divide.
// Define F2V_SMOOTHING_EN to make out follow target through a first-order IIR instead of directly.
module square_wave_f2v
    import f2v_pkg::*;
#(
    parameter int unsigned CLOCK_RATE     = 50000000,
    parameter int unsigned F_FULL_SCALE   = 20000,
    parameter int          THRESH_HI      = 24576,
    parameter int          THRESH_LO      = 8192,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned SMOOTH_SHIFT   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     audio_clk_en,
    input  logic signed [DATA_W-1:0] in,
    output logic signed [DATA_W-1:0] out,
    output logic                     locked
);

    localparam logic [63:0]             K_FULL    = calc_k(64'(CLOCK_RATE), 64'(F_FULL_SCALE));
    localparam logic [PERIOD_W-1:0]     K_DIVIDND = PERIOD_W'(K_FULL);
    localparam logic [PERIOD_W-1:0]     TIMEOUT_V = PERIOD_W'(TIMEOUT_CYCLES);
    localparam logic signed [DATA_W-1:0] TH_HI    = DATA_W'(THRESH_HI);
    localparam logic signed [DATA_W-1:0] TH_LO    = DATA_W'(THRESH_LO);

    f2v_state_e                state_q;
    f2v_state_e                state_next;
    logic                      level_q;
    logic                      level_next_c;
    logic                      edge_c;
    logic [PERIOD_W-1:0]       count_q;
    logic                      start_c;
    logic                      timeout_c;
    logic                      div_busy;
    logic                      div_done;
    logic [PERIOD_W-1:0]       div_quotient;
    logic signed [DATA_W-1:0]  target_q;
    logic signed [DATA_W-1:0]  out_next_c;

    // Hysteresis comparator, evaluated only on strobe cycles.
    always_comb begin
        level_next_c = level_q;
        if (audio_clk_en) begin
            if (in > TH_HI) begin
                level_next_c = 1'b1;
            end else if (in < TH_LO) begin
                level_next_c = 1'b0;
            end
        end
        edge_c = level_next_c & ~level_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            level_q <= level_next_c;
            if (edge_c) begin
                count_q <= PERIOD_W'(1);
            end else if (count_q != TIMEOUT_V) begin
                count_q <= count_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_next;
        end
    end

    // An edge while measuring beats a coincident timeout; a busy divider drops the edge's period.
    always_comb begin
        state_next = state_q;
        start_c    = 1'b0;
        timeout_c  = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (edge_c) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_c) begin
                    start_c = ~div_busy;
                end else if (count_q == TIMEOUT_V) begin
                    timeout_c  = 1'b1;
                    state_next = WAIT_FIRST;
                end
            end
            default: state_next = WAIT_FIRST;
        endcase
    end

    seq_divider u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_c),
        .dividend (K_DIVIDND),
        .divisor  (count_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // A result arriving after the FSM has fallen back to WAIT_FIRST is stale and ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= '0;
            locked   <= 1'b0;
        end else if (timeout_c) begin
            target_q <= '0;
            locked   <= 1'b0;
        end else if (div_done && state_q == MEASURE) begin
            target_q <= (div_quotient > OUT_MAX) ? DATA_W'(OUT_MAX) : DATA_W'(div_quotient);
            locked   <= 1'b1;
        end
    end

`ifdef F2V_SMOOTHING_EN
    logic signed [DATA_W:0] diff_c;
    logic signed [DATA_W:0] step_c;

    // A zero step near target is forced to +/-1 so out lands exactly on target.
    always_comb begin
        diff_c = (DATA_W+1)'(target_q) - (DATA_W+1)'(out);
        step_c = diff_c >>> SMOOTH_SHIFT;
        if (step_c == '0 && diff_c != '0) begin
            step_c = diff_c[DATA_W] ? -(DATA_W+1)'(1) : (DATA_W+1)'(1);
        end
        out_next_c = DATA_W'((DATA_W+1)'(out) + step_c);
    end
`else
    logic unused_smooth_shift;
    assign unused_smooth_shift = ^SMOOTH_SHIFT;

    always_comb begin
        out_next_c = target_q;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else if (audio_clk_en) begin
            out <= out_next_c;
        end
    end

endmodule

// File: tb/tb_square_wave_f2v.sv
// Directed bench for square_wave_f2v with a 1 MHz clock model so periods stay short.
// K = 32767 * 1e6 / 20000 = 1638350; a 1000-cycle period maps to 1638.
module tb_square_wave_f2v;

    localparam int unsigned CLK_RATE = 1000000;
    localparam int unsigned F_FS     = 20000;
    localparam int unsigned TIMEOUT  = 5000;

    localparam logic signed [15:0] V_HI = 16'sd32767;
    localparam logic signed [15:0] V_LO = 16'sd0;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               audio_clk_en;
    logic signed [15:0] in;
    logic signed [15:0] out;
    logic               locked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    square_wave_f2v #(
        .CLOCK_RATE     (CLK_RATE),
        .F_FULL_SCALE   (F_FS),
        .THRESH_HI      (24576),
        .THRESH_LO      (8192),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SMOOTH_SHIFT   (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_clk_en (audio_clk_en),
        .in           (in),
        .out          (out),
        .locked       (locked)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        in           = V_LO;
        audio_clk_en = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        int bad;
        reset_n      = 1'b0;
        audio_clk_en = 1'b1;
        in           = V_HI;
        tick(2);
        checks++;
        if (out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_out: got %0d expected 0", out);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked: got %0b expected 0", locked);
        end
        in      = V_LO;
        reset_n = 1'b1;
        bad     = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (out !== 16'sd0 || locked !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_1khz();
        apply_reset();
        tick(10);
        in = V_HI;
        tick(500);
        in = V_LO;
        tick(500);
        in = V_HI;
        tick(33);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: got %0b expected 0", locked);
        end
        tick(1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_time: got %0b expected 1", locked);
        end
        checks++;
        if (out !== 16'sd0) begin
            errors++;
            $display("FAIL out_before_strobe: got %0d expected 0", out);
        end
        tick(1);
`ifdef F2V_SMOOTHING_EN
        begin
            logic signed [15:0] prev;
            int                 bad;
            checks++;
            if (out !== 16'sd102) begin
                errors++;
                $display("FAIL smooth_first: got %0d expected 102", out);
            end
            prev = out;
            bad  = 0;
            for (int i = 0; i < 300 && out != 16'sd1638; i++) begin
                tick(1);
                if (out < prev) bad++;
                prev = out;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL smooth_monotonic: got %0d decreases expected 0", bad);
            end
            checks++;
            if (out !== 16'sd1638) begin
                errors++;
                $display("FAIL smooth_final: got %0d expected 1638", out);
            end
        end
`else
        checks++;
        if (out !== 16'sd1638) begin
            errors++;
            $display("FAIL out_1khz: got %0d expected 1638", out);
        end
`endif
    endtask

    task automatic test_midrange();
        apply_reset();
        in = V_HI;
        tick(388);
        in = V_LO;
        tick(389);
        in = V_HI;
        for (int i = 0; i < 400 && out != 16'sd2108; i++) tick(1);
        checks++;
        if (out !== 16'sd2108) begin
            errors++;
            $display("FAIL out_p777: got %0d expected 2108", out);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_p777: got %0b expected 1", locked);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            in = V_HI;
            tick(25);
            in = V_LO;
            tick(25);
        end
        for (int i = 0; i < 400 && out != 16'sd32767; i++) tick(1);
        checks++;
        if (out !== 16'sd32767 || locked !== 1'b1) begin
            errors++;
            $display("FAIL full_scale_20k: got out %0d locked %0b expected 32767 1", out, locked);
        end
        // 25-cycle period: K/P = 65534 must clamp; edges during a busy divide are dropped.
        apply_reset();
        for (int p = 0; p < 8; p++) begin
            in = V_HI;
            tick(12);
            in = V_LO;
            tick(13);
        end
        for (int i = 0; i < 400 && out != 16'sd32767; i++) tick(1);
        checks++;
        if (out !== 16'sd32767 || locked !== 1'b1) begin
            errors++;
            $display("FAIL saturate_40k: got out %0d locked %0b expected 32767 1", out, locked);
        end
    endtask

    task automatic test_no_edges();
        apply_reset();
        in = 16'sd20000;
        tick(100);
        for (int i = 0; i < 50; i++) begin
            in = 16'sd10000;
            tick(3);
            in = 16'sd20000;
            tick(3);
        end
        checks++;
        if (locked !== 1'b0 || out !== 16'sd0) begin
            errors++;
            $display("FAIL no_edge: got out %0d locked %0b expected 0 0", out, locked);
        end
        // Dip to 20000 between highs must not re-arm; only the 5000 dip does, giving P = 400.
        in = 16'sd30000;
        tick(100);
        in = 16'sd20000;
        tick(100);
        in = 16'sd30000;
        tick(100);
        in = 16'sd5000;
        tick(100);
        in = 16'sd30000;
        for (int i = 0; i < 400 && out != 16'sd4095; i++) tick(1);
        checks++;
        if (out !== 16'sd4095 || locked !== 1'b1) begin
            errors++;
            $display("FAIL hysteresis_p400: got out %0d locked %0b expected 4095 1", out, locked);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        in = V_HI;
        tick(500);
        in = V_LO;
        tick(500);
        in = V_HI;
        tick(500);
        in = V_LO;
        tick(4500);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL to_hold: got %0b expected 1", locked);
        end
        tick(1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL to_drop: got %0b expected 0", locked);
        end
        for (int i = 0; i < 400 && out != 16'sd0; i++) tick(1);
        checks++;
        if (out !== 16'sd0) begin
            errors++;
            $display("FAIL to_out: got %0d expected 0", out);
        end
        in = V_HI;
        tick(40);
        checks++;
        if (locked !== 1'b0 || out !== 16'sd0) begin
            errors++;
            $display("FAIL first_after_to: got out %0d locked %0b expected 0 0", out, locked);
        end
        tick(460);
        in = V_LO;
        tick(500);
        in = V_HI;
        for (int i = 0; i < 400 && out != 16'sd1638; i++) tick(1);
        checks++;
        if (out !== 16'sd1638 || locked !== 1'b1) begin
            errors++;
            $display("FAIL relock: got out %0d locked %0b expected 1638 1", out, locked);
        end
    endtask

    task automatic test_reset_mid_divide();
        apply_reset();
        in = V_HI;
        tick(500);
        in = V_LO;
        tick(500);
        in = V_HI;
        tick(10);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(60);
        checks++;
        if (locked !== 1'b0 || out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_abort: got out %0d locked %0b expected 0 0", out, locked);
        end
    endtask

    initial begin
        test_reset();
        test_1khz();
        test_midrange();
        test_saturation();
        test_no_edges();
        test_timeout();
        test_reset_mid_divide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
